// File: rtl/deca_sequencer.sv
// DECA CPU control-state sequencer: one-hot FETCH/EXEC1/EXEC2 strobes,
// optional fetch overlap on the last execute cycle, saturating perf counters.
module deca_sequencer #(
  parameter bit PIPE_EN = 1'b1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             step,
  input  logic             EXTRA,
  input  logic             STP,
  input  logic             P,
  input  logic             PC_sload,
  output logic             FETCH,
  output logic             EXEC1,
  output logic             EXEC2,
  output logic             IR_load,
  output logic             BeenPipelined,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC1,
    S_EXEC2,
    S_HALT
  } state_t;

  state_t state;

  logic stop_cycle;
  logic eoi;
  logic overlap;
  logic instr_done;
  logic active;

  assign FETCH  = (state == S_FETCH);
  assign EXEC1  = (state == S_EXEC1);
  assign EXEC2  = (state == S_EXEC2);
  assign halted = (state == S_HALT);
  assign active = FETCH | EXEC1 | EXEC2;

  // STP outranks EXTRA, so an EXEC1 with STP is never an end-of-instruction cycle.
  assign stop_cycle = EXEC1 & STP;
  assign eoi        = (EXEC1 & ~STP & ~EXTRA) | EXEC2;
  assign overlap    = eoi & run & PIPE_EN & P & ~PC_sload;
  assign instr_done = eoi | stop_cycle;
  assign IR_load    = FETCH | overlap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      BeenPipelined <= 1'b0;
      instr_count   <= '0;
      cycle_count   <= '0;
    end else begin
      if (active && cycle_count != '1)
        cycle_count <= cycle_count + CNT_W'(1);
      if (instr_done && instr_count != '1)
        instr_count <= instr_count + CNT_W'(1);

      case (state)
        S_IDLE: begin
          BeenPipelined <= 1'b0;
          if (run || step)
            state <= S_FETCH;
        end
        S_FETCH: begin
          state <= S_EXEC1;
        end
        S_EXEC1, S_EXEC2: begin
          if (stop_cycle) begin
            state         <= S_HALT;
            BeenPipelined <= 1'b0;
          end else if (EXEC1 && EXTRA) begin
            state <= S_EXEC2;
          end else if (!run) begin
            state         <= S_IDLE;
            BeenPipelined <= 1'b0;
          end else if (overlap) begin
            state         <= S_EXEC1;
            BeenPipelined <= 1'b1;
          end else begin
            state         <= S_FETCH;
            BeenPipelined <= 1'b0;
          end
        end
        S_HALT: begin
          BeenPipelined <= 1'b0;
        end
        default: begin
          state         <= S_IDLE;
          BeenPipelined <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_deca_sequencer.sv
// Bench for deca_sequencer: two instances (overlap on with 4-bit counters,
// strict sequencing with 16-bit counters) checked against an instruction-level model.
module tb_deca_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  logic run, step, extra, stp, p, sload;

  logic a_fetch, a_e1, a_e2, a_irl, a_bp, a_halt;
  logic [3:0] a_ic, a_cc;
  logic b_fetch, b_e1, b_e2, b_irl, b_bp, b_halt;
  logic [15:0] b_ic, b_cc;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // model: mode 0=idle 1=running 2=halted; ph = cycle index within instruction
  int m_mode[2];
  int m_ph[2];
  int m_bp[2];
  int m_ic[2];
  int m_cc[2];
  int m_max[2]  = '{15, 65535};
  bit m_pipe[2] = '{1'b1, 1'b0};

  always #5 clk = ~clk;

  deca_sequencer #(.PIPE_EN(1'b1), .CNT_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step), .EXTRA(extra), .STP(stp),
    .P(p), .PC_sload(sload), .FETCH(a_fetch), .EXEC1(a_e1), .EXEC2(a_e2),
    .IR_load(a_irl), .BeenPipelined(a_bp), .halted(a_halt),
    .instr_count(a_ic), .cycle_count(a_cc)
  );

  deca_sequencer #(.PIPE_EN(1'b0), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step), .EXTRA(extra), .STP(stp),
    .P(p), .PC_sload(sload), .FETCH(b_fetch), .EXEC1(b_e1), .EXEC2(b_e2),
    .IR_load(b_irl), .BeenPipelined(b_bp), .halted(b_halt),
    .instr_count(b_ic), .cycle_count(b_cc)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_ph[k] = 0; m_bp[k] = 0; m_ic[k] = 0; m_cc[k] = 0;
    end
  endtask

  function automatic bit m_end(input int k);
    return (m_mode[k] == 1) &&
           ((m_ph[k] == 1 && !stp && !extra) || m_ph[k] == 2);
  endfunction

  function automatic bit m_ov(input int k);
    return m_end(k) && run && m_pipe[k] && p && !sload;
  endfunction

  task automatic check_all();
    int exp_v, obs_v, obs_ic, obs_cc;
    bit f, e1, e2;
    for (int k = 0; k < 2; k++) begin
      f  = (m_mode[k] == 1) && (m_ph[k] == 0);
      e1 = (m_mode[k] == 1) && (m_ph[k] == 1);
      e2 = (m_mode[k] == 1) && (m_ph[k] == 2);
      exp_v = {26'd0, f, e1, e2, f | m_ov(k), m_bp[k] != 0, m_mode[k] == 2};
      if (k == 0) begin
        obs_v  = {26'd0, a_fetch, a_e1, a_e2, a_irl, a_bp, a_halt};
        obs_ic = int'(a_ic);
        obs_cc = int'(a_cc);
      end else begin
        obs_v  = {26'd0, b_fetch, b_e1, b_e2, b_irl, b_bp, b_halt};
        obs_ic = int'(b_ic);
        obs_cc = int'(b_cc);
      end
      check($sformatf("inst%0d.F/E1/E2/IR/BP/H", k), obs_v, exp_v);
      check($sformatf("inst%0d.instr_count", k), obs_ic, m_ic[k]);
      check($sformatf("inst%0d.cycle_count", k), obs_cc, m_cc[k]);
    end
  endtask

  // advance the model over one clock edge using the inputs held across it
  task automatic model_step();
    bit ov;
    for (int k = 0; k < 2; k++) begin
      ov = m_ov(k);
      if (m_mode[k] == 0) begin
        if (run || step) begin m_mode[k] = 1; m_ph[k] = 0; end
      end else if (m_mode[k] == 1) begin
        if (m_cc[k] < m_max[k]) m_cc[k]++;
        if (m_ph[k] == 0) begin
          m_ph[k] = 1;
        end else if (m_ph[k] == 1 && stp) begin
          m_mode[k] = 2; m_bp[k] = 0;
          if (m_ic[k] < m_max[k]) m_ic[k]++;
        end else if (m_ph[k] == 1 && extra) begin
          m_ph[k] = 2;
        end else begin
          if (m_ic[k] < m_max[k]) m_ic[k]++;
          if (!run)    begin m_mode[k] = 0; m_bp[k] = 0; end
          else if (ov) begin m_ph[k] = 1;   m_bp[k] = 1; end
          else         begin m_ph[k] = 0;   m_bp[k] = 0; end
        end
      end
    end
  endtask

  // one clock: apply inputs, check mid-cycle, take the edge
  task automatic cyc(input bit r, input bit s, input bit x, input bit t,
                     input bit pp, input bit j);
    run = r; step = s; extra = x; stp = t; p = pp; sload = j;
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    run = 0; step = 0; extra = 0; stp = 0; p = 0; sload = 0;
    model_reset();
    #3;
    check_all();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // LDI-like, strictly sequenced
    repeat (5) cyc(1, 0, 0, 0, 0, 0);
    check("ldi.instr_count", int'(b_ic), 2);
    check("ldi.cycle_count", int'(b_cc), 4);
    check("ldi.bp", int'(b_bp), 0);

    // pipelineable stream: A overlaps, B alternates
    do_reset();
    repeat (6) cyc(1, 0, 0, 0, 1, 0);
    check("pipe.a_instr_count", int'(a_ic), 4);
    check("pipe.a_bp", int'(a_bp), 1);
    check("pipe.b_instr_count", int'(b_ic), 2);

    // ADD-like and taken jumps
    repeat (6) cyc(1, 0, 1, 0, 1, 0);
    repeat (4) cyc(1, 0, 0, 0, 1, 1);
    check("jump.a_bp", int'(a_bp), 0);

    // single step, with a step pulse inside the instruction
    do_reset();
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0, 0);
    check("step.instr_count", int'(b_ic), 1);
    check("step.idle_fetch", int'(b_fetch), 0);

    // STP together with EXTRA halts; run/step are then ignored
    repeat (4) cyc(1, 0, 1, 1, 1, 0);
    repeat (3) cyc(1, 1, 0, 0, 0, 0);
    check("halt.halted", int'(a_halt), 1);
    check("halt.instr_count", int'(b_ic), 2);
    do_reset();
    check("halt.reset_clears", int'(a_halt), 0);

    // saturation of the 4-bit counters
    repeat (21) cyc(1, 0, 0, 0, 0, 0);
    check("sat.a_cycle_count", int'(a_cc), 15);
    check("sat.b_cycle_count", int'(b_cc), 20);

    // randomized traffic with occasional asynchronous resets
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0)
        do_reset();
      else
        cyc($urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 29) == 0,
            $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/deca_sequencer.md
Name: deca_sequencer

Overview:
- Control-state sequencer for the DECA CPU. It generates the one-hot FETCH/EXEC1/EXEC2 cycle strobes that the instruction decoder consumes.
- It honours the decoder's EXTRA and STP indications and supports free-run and single-step execution.
- Optionally it overlaps the next instruction fetch with the last execute cycle of a pipelineable instruction, and flags that with BeenPipelined.
- It keeps instruction and active-cycle counters for performance measurement.

Parameters:
- PIPE_EN, 1, 1 = overlapped fetch allowed; 0 = strict FETCH->EXEC sequencing.
- CNT_W, 16, width of instr_count and cycle_count.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  level; 1 = free-run, 0 = stop at the next instruction boundary.
- step  in  1  single-cycle pulse; starts exactly one instruction from IDLE.
- EXTRA  in  1  from decoder; instruction needs EXEC2 (valid in EXEC1).
- STP  in  1  from decoder; current IR is the stop opcode.
- P  in  1  from decoder; current instruction is pipelineable.
- PC_sload  in  1  from decoder; taken jump this cycle.
- FETCH  out  1  fetch cycle strobe.
- EXEC1  out  1  first execute cycle strobe.
- EXEC2  out  1  second execute cycle strobe.
- IR_load  out  1  load instruction register this cycle.
- BeenPipelined  out  1  current instruction was fetched in overlap.
- halted  out  1  CPU stopped by STP.
- instr_count  out  CNT_W  completed instructions, saturating.
- cycle_count  out  CNT_W  cycles spent in FETCH/EXEC1/EXEC2, saturating.

Behaviour:
- States: IDLE, FETCH, EXEC1, EXEC2, HALT. The state register is encoded as desired.
- FETCH/EXEC1/EXEC2 are Moore outputs decoded from state and are mutually exclusive.
- Reset (rst_n=0, async):
  - state=IDLE, BeenPipelined=0, counters=0.
  - All outputs 0 within the same cycle.
  - Reset mid-instruction aborts it with no count update.
- IDLE:
  - All strobes 0.
  - If run=1 or step=1, next state is FETCH; otherwise stay.
  - step outside IDLE is ignored.
- FETCH:
  - IR_load=1, next state EXEC1.
  - BeenPipelined is cleared on entry to FETCH.
- EXEC1:
  - If STP=1: next state HALT, instruction counted. STP has priority over everything else.
  - Else if EXTRA=1: next state EXEC2.
  - Else this is the end-of-instruction cycle (EOI); apply the EOI rule.
- EXEC2: always EOI.
- EOI rule, evaluated on the EOI cycle, first match wins:
  - run=0: next state IDLE.
  - PIPE_EN=1 and P=1 and PC_sload=0: IR_load=1 in this cycle, next state EXEC1, BeenPipelined<=1.
  - Otherwise: next state FETCH.
  - instr_count increments on every EOI cycle and on the STP cycle.
- BeenPipelined timing:
  - Registered; it becomes 1 in the EXEC1 following an overlapped fetch.
  - It holds through that instruction's EXEC2.
  - It is cleared on entry to FETCH, IDLE or HALT.
- HALT:
  - halted=1, all strobes 0, IR_load=0.
  - Sticky; only rst_n exits, and run/step are ignored.
- IR_load is combinational: IR_load = FETCH | (EOI & overlap condition). It is never 1 in IDLE or HALT.
- cycle_count increments in each FETCH/EXEC1/EXEC2 cycle.
- Both counters saturate at 2^CNT_W-1 and never wrap.
- run deasserted mid-instruction lets the instruction finish, then enters IDLE.
- Simultaneous EXTRA and STP in EXEC1: STP wins.
- Taken jump (PC_sload=1) on EOI always forces the next state to FETCH.

Test Plan:
- Reset then run=1, LDI-like instruction (EXTRA=0, P=0) repeated → FETCH,EXEC1,FETCH,EXEC1; after 4 cycles instr_count=2, cycle_count=4, BeenPipelined=0.
- run=1, PIPE_EN=1, P=1, EXTRA=0, PC_sload=0 → after the first FETCH the sequence is EXEC1 continuously, IR_load=1 each cycle and BeenPipelined=1 from the second EXEC1.
  - With PIPE_EN=0 under the same stimulus, FETCH/EXEC1 alternate.
- ADD-like instruction (EXTRA=1 in EXEC1, P=1) → EXEC1,EXEC2, with the overlap at EXEC2 and the next state EXEC1. instr_count increments only on EXEC2.
- Taken jump: P=1, PC_sload=1 in EXEC1 → next state FETCH, BeenPipelined=0.
- run=0, step pulse in IDLE → exactly one FETCH,EXEC1 pair, then IDLE, instr_count=1.
  - A step pulse during EXEC1 is ignored.
- STP=1 (EXTRA=1 too) in EXEC1 → HALT next cycle, halted=1, strobes 0, counters frozen, run/step ignored.
  - rst_n low asynchronously → IDLE, halted=0, counters=0.
- Preload counters near saturation (CNT_W=4, run 20 cycles) → cycle_count holds at 15, no wrap.
